// File: rtl/lieat_ifu_ifetch_gen_if.sv
// Handshake bundle between IFU decode/branch logic, the fetch generator and the I-cache port.
// The slave modport is the generator's view; master is the surrounding logic's view.
interface lieat_ifu_ifetch_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_i_flush;
  logic [XLEN-1:0] req_i_flush_pc;
  logic            req_i_valid;
  logic            req_i_ready;
  logic [XLEN-1:0] req_i_pc;
  logic            req_i_bxx;
  logic            req_i_jal;
  logic            req_i_rs1en;
  logic            req_i_rs1dep;
  logic            req_i_bxx_taken;
  logic [XLEN-1:0] req_i_src1;
  logic [XLEN-1:0] req_i_imm;
  logic            req_i_fencei;
  logic            req_i_nojump;
  logic            req_i_fencei_over;
  logic            req_o_ready;
  logic            req_o_valid;
  logic [XLEN-1:0] req_o_pc;
  logic            gen_busy;

  modport slave (
    input  req_i_flush, req_i_flush_pc, req_i_valid, req_i_pc, req_i_bxx, req_i_jal,
           req_i_rs1en, req_i_rs1dep, req_i_bxx_taken, req_i_src1, req_i_imm,
           req_i_fencei, req_i_nojump, req_i_fencei_over, req_o_ready,
    output req_i_ready, req_o_valid, req_o_pc, gen_busy
  );

  modport master (
    output req_i_flush, req_i_flush_pc, req_i_valid, req_i_pc, req_i_bxx, req_i_jal,
           req_i_rs1en, req_i_rs1dep, req_i_bxx_taken, req_i_src1, req_i_imm,
           req_i_fencei, req_i_nojump, req_i_fencei_over, req_o_ready,
    input  req_i_ready, req_o_valid, req_o_pc, gen_busy
  );
endinterface

// File: rtl/lieat_ifu_ifetch_gen.sv
// Next-PC generator with a small fetch-request FIFO in front of the I-cache request port.
// Handles boot PC, sequential/branch/jalr targets, rs1 dependency wait, fence.i stall and flush.
module lieat_ifu_ifetch_gen #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] PC_DEFAULT  = 32'h80000000,
  parameter int unsigned     FETCH_BYTES = 4,
  parameter int unsigned     RQ_DEPTH    = 2
) (
  input logic                   clock,
  input logic                   reset,
  lieat_ifu_ifetch_gen_if.slave bus
);

  localparam int unsigned     AW = $clog2(RQ_DEPTH);
  localparam logic [XLEN-1:0] FB = XLEN'(FETCH_BYTES);

  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StWait = 3'b010,
    StVald = 3'b100
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] mem_q [RQ_DEPTH];
  logic [AW-1:0]   rptr_q, wptr_q;
  logic [AW:0]     cnt_q;
  logic            fencei_wait_q, boot_pend_q;
  logic [XLEN-1:0] tgt_q, pc_lat_q, imm_lat_q;

  logic            flush, empty, full, acc, deq, enq_ok, push, fencei_fire;
  logic            enq_valid, out_valid;
  logic [XLEN-1:0] enq_pc, out_pc, seq_pc, base, target;

  always_comb begin
    flush       = bus.req_i_flush;
    empty       = (cnt_q == '0);
    full        = (cnt_q == (AW+1)'(RQ_DEPTH));
    bus.req_i_ready = ~flush & ~full & (state_q == StIdle) & ~fencei_wait_q & ~boot_pend_q;
    acc         = bus.req_i_valid & bus.req_i_ready;
    seq_pc      = bus.req_i_pc + FB;
    base        = bus.req_i_rs1en ? bus.req_i_src1 : bus.req_i_pc;
    target      = (bus.req_i_bxx & ~bus.req_i_bxx_taken) ? seq_pc : base + bus.req_i_imm;
    deq         = ~flush & ~boot_pend_q & ~empty & bus.req_o_ready;
    enq_ok      = ~full | deq;
    fencei_fire = ~flush & fencei_wait_q & bus.req_i_fencei_over;

    // Enqueue sources are mutually exclusive: fence.i and WAIT/VALD all block req_i.
    enq_valid = 1'b0;
    enq_pc    = tgt_q;
    if (!flush) begin
      if (state_q == StVald && enq_ok) begin
        enq_valid = 1'b1;
        enq_pc    = tgt_q;
      end else if (fencei_fire && enq_ok) begin
        enq_valid = 1'b1;
        enq_pc    = pc_lat_q + FB;
      end else if (acc && !bus.req_i_fencei && bus.req_i_nojump) begin
        enq_valid = 1'b1;
        enq_pc    = seq_pc;
      end
    end
    // A bypassed request accepted downstream in the same cycle is never stored.
    push = enq_valid & ~(empty & bus.req_o_ready);

    if (flush) begin
      out_valid = 1'b1;
      out_pc    = bus.req_i_flush_pc;
    end else if (boot_pend_q) begin
      out_valid = 1'b1;
      out_pc    = PC_DEFAULT;
    end else if (!empty) begin
      out_valid = 1'b1;
      out_pc    = mem_q[rptr_q];
    end else begin
      out_valid = enq_valid;
      out_pc    = enq_pc;
    end
    bus.req_o_valid = out_valid & ~reset;
    bus.req_o_pc    = out_pc;
    bus.gen_busy    = ~empty | (state_q != StIdle);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      rptr_q        <= '0;
      wptr_q        <= '0;
      cnt_q         <= '0;
      fencei_wait_q <= 1'b0;
      boot_pend_q   <= 1'b1;
      tgt_q         <= '0;
      pc_lat_q      <= '0;
      imm_lat_q     <= '0;
      for (int i = 0; i < int'(RQ_DEPTH); i++) mem_q[i] <= '0;
    end else if (flush) begin
      state_q       <= StIdle;
      fencei_wait_q <= 1'b0;
      boot_pend_q   <= 1'b0;
      rptr_q        <= '0;
      if (bus.req_o_ready) begin
        wptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        mem_q[0] <= bus.req_i_flush_pc;
        wptr_q   <= AW'(1);
        cnt_q    <= (AW+1)'(1);
      end
    end else begin
      if (boot_pend_q && bus.req_o_ready) boot_pend_q <= 1'b0;
      if (push) begin
        mem_q[wptr_q] <= enq_pc;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (deq) rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(deq);

      unique case (state_q)
        StIdle: begin
          if (acc) begin
            if (bus.req_i_fencei) begin
              fencei_wait_q <= 1'b1;
              pc_lat_q      <= bus.req_i_pc;
            end else if (bus.req_i_nojump) begin
              state_q <= StIdle;
            end else if (bus.req_i_rs1en && bus.req_i_rs1dep) begin
              pc_lat_q  <= bus.req_i_pc;
              imm_lat_q <= bus.req_i_imm;
              state_q   <= StWait;
            end else if (bus.req_i_bxx || bus.req_i_jal || bus.req_i_rs1en) begin
              tgt_q   <= target;
              state_q <= StVald;
            end
          end
        end
        StWait: begin
          if (!bus.req_i_rs1dep) begin
            tgt_q   <= bus.req_i_src1 + imm_lat_q;
            state_q <= StVald;
          end
        end
        StVald: begin
          if (enq_ok) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // fence.i completion with a full queue parks the resume PC in VALD so it is not lost.
      if (fencei_fire) begin
        fencei_wait_q <= 1'b0;
        if (!enq_ok) begin
          tgt_q   <= pc_lat_q + FB;
          state_q <= StVald;
        end
      end
    end
  end

endmodule

// File: tb/tb_lieat_ifu_ifetch_gen.sv
// Directed bench for lieat_ifu_ifetch_gen: boot, sequential bypass, jalr wait, back-pressure,
// fence.i stall, flush, PC wrap and async reset mid-operation.
module tb_lieat_ifu_ifetch_gen;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  lieat_ifu_ifetch_gen_if #(.XLEN(32)) bus ();
  lieat_ifu_ifetch_gen_if #(.XLEN(32)) bus8 ();

  lieat_ifu_ifetch_gen #(.XLEN(32), .FETCH_BYTES(4), .RQ_DEPTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  lieat_ifu_ifetch_gen #(.XLEN(32), .FETCH_BYTES(8), .RQ_DEPTH(2)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (bus8)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_i_flush = 0;  bus.req_i_flush_pc = '0; bus.req_i_valid = 0; bus.req_i_pc = '0;
    bus.req_i_bxx = 0;    bus.req_i_jal = 0;       bus.req_i_rs1en = 0; bus.req_i_rs1dep = 0;
    bus.req_i_bxx_taken = 0; bus.req_i_src1 = '0;  bus.req_i_imm = '0;  bus.req_i_fencei = 0;
    bus.req_i_nojump = 0; bus.req_i_fencei_over = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.req_o_ready = 1;
    repeat (2) @(posedge clock);
    #1;
    tests_run++;
    if (bus.req_o_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b want 0", bus.req_o_valid);
    end
    tests_run++;
    if (bus.req_o_pc !== 32'h80000000) begin
      fails++; $display("FAIL reset_pc: got %h want 80000000", bus.req_o_pc);
    end
    tests_run++;
    if (bus.gen_busy !== 1'b0 || bus.req_i_ready !== 1'b0) begin
      fails++; $display("FAIL reset_busy_ready: got %b%b want 00", bus.gen_busy, bus.req_i_ready);
    end
    reset = 0;
    #1;
    tests_run++;
    if (bus.req_o_valid !== 1'b1 || bus.req_o_pc !== 32'h80000000) begin
      fails++; $display("FAIL boot_req: got %b/%h want 1/80000000", bus.req_o_valid, bus.req_o_pc);
    end
    tick();
    tests_run++;
    if (bus.req_o_valid !== 1'b0 || bus.req_i_ready !== 1'b1) begin
      fails++; $display("FAIL boot_done: got v=%b r=%b want 0 1", bus.req_o_valid, bus.req_i_ready);
    end
  endtask

  task automatic test_seq();
    bus.req_i_valid = 1; bus.req_i_pc = 32'h100; bus.req_i_nojump = 1;
    bus8.req_i_valid = 1; bus8.req_i_pc = 32'h100; bus8.req_i_nojump = 1;
    #1;
    tests_run++;
    if (bus.req_o_valid !== 1'b1 || bus.req_o_pc !== 32'h104) begin
      fails++; $display("FAIL seq_bypass: got %b/%h want 1/104", bus.req_o_valid, bus.req_o_pc);
    end
    tests_run++;
    if (bus8.req_o_valid !== 1'b1 || bus8.req_o_pc !== 32'h108) begin
      fails++; $display("FAIL seq_bypass8: got %b/%h want 1/108", bus8.req_o_valid, bus8.req_o_pc);
    end
    tick();
    clear_inputs();
    bus8.req_i_valid = 0; bus8.req_i_nojump = 0;
    #1;
    tests_run++;
    if (bus.req_o_valid !== 1'b0 || bus.gen_busy !== 1'b0) begin
      fails++; $display("FAIL seq_not_stored: got v=%b busy=%b want 0 0", bus.req_o_valid, bus.gen_busy);
    end
  endtask

  task automatic test_jalr_wait();
    bus.req_i_valid = 1; bus.req_i_pc = 32'h200; bus.req_i_rs1en = 1; bus.req_i_rs1dep = 1;
    bus.req_i_imm = 32'h10; bus.req_i_src1 = 32'hdead;
    #1;
    tests_run++;
    if (bus.req_i_ready !== 1'b1 || bus.req_o_valid !== 1'b0) begin
      fails++; $display("FAIL jalr_accept: got r=%b v=%b want 1 0", bus.req_i_ready, bus.req_o_valid);
    end
    tick();
    bus.req_i_valid = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        bus.req_i_rs1dep = 0; bus.req_i_src1 = 32'h2000;
      end
      #1;
      tests_run++;
      if (bus.req_i_ready !== 1'b0 || bus.req_o_valid !== 1'b0 || bus.gen_busy !== 1'b1) begin
        fails++;
        $display("FAIL jalr_wait%0d: got r=%b v=%b busy=%b want 0 0 1", i, bus.req_i_ready,
                 bus.req_o_valid, bus.gen_busy);
      end
      tick();
    end
    tests_run++;
    if (bus.req_o_valid !== 1'b1 || bus.req_o_pc !== 32'h2010 || bus.req_i_ready !== 1'b0) begin
      fails++;
      $display("FAIL jalr_vald: got %b/%h r=%b want 1/2010 r=0", bus.req_o_valid, bus.req_o_pc,
               bus.req_i_ready);
    end
    tick();
    clear_inputs();
    #1;
    tests_run++;
    if (bus.req_o_valid !== 1'b0 || bus.req_i_ready !== 1'b1) begin
      fails++; $display("FAIL jalr_idle: got v=%b r=%b want 0 1", bus.req_o_valid, bus.req_i_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc [2];
    exp_pc[0] = 32'h104;
    exp_pc[1] = 32'h108;
    bus.req_o_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus.req_i_valid = 1; bus.req_i_nojump = 1; bus.req_i_pc = 32'h100 + 32'(4 * i);
      #1;
      tests_run++;
      if (bus.req_i_ready !== (i < 2) || bus.req_o_valid !== 1'b1 || bus.req_o_pc !== 32'h104) begin
        fails++;
        $display("FAIL bp_fill%0d: got r=%b v=%b pc=%h want r=%b v=1 pc=104", i, bus.req_i_ready,
                 bus.req_o_valid, bus.req_o_pc, (i < 2));
      end
      if (i < 2) tick();
    end
    clear_inputs();
    bus.req_o_ready = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if (bus.req_o_valid !== 1'b1 || bus.req_o_pc !== exp_pc[i]) begin
        fails++;
        $display("FAIL bp_drain%0d: got %b/%h want 1/%h", i, bus.req_o_valid, bus.req_o_pc, exp_pc[i]);
      end
      tick();
    end
    tests_run++;
    if (bus.req_o_valid !== 1'b0 || bus.gen_busy !== 1'b0) begin
      fails++; $display("FAIL bp_empty: got v=%b busy=%b want 0 0", bus.req_o_valid, bus.gen_busy);
    end
  endtask

  task automatic test_fencei();
    bus.req_i_valid = 1; bus.req_i_fencei = 1; bus.req_i_pc = 32'h300;
    #1;
    tests_run++;
    if (bus.req_i_ready !== 1'b1 || bus.req_o_valid !== 1'b0) begin
      fails++; $display("FAIL fencei_accept: got r=%b v=%b want 1 0", bus.req_i_ready, bus.req_o_valid);
    end
    tick();
    bus.req_i_fencei = 0; bus.req_i_nojump = 1; bus.req_i_pc = 32'h500;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (bus.req_i_ready !== 1'b0 || bus.req_o_valid !== 1'b0) begin
        fails++;
        $display("FAIL fencei_stall%0d: got r=%b v=%b want 0 0", i, bus.req_i_ready, bus.req_o_valid);
      end
      tick();
    end
    clear_inputs();
    bus.req_i_fencei_over = 1;
    #1;
    tests_run++;
    if (bus.req_o_valid !== 1'b1 || bus.req_o_pc !== 32'h304) begin
      fails++; $display("FAIL fencei_resume: got %b/%h want 1/304", bus.req_o_valid, bus.req_o_pc);
    end
    tick();
    bus.req_i_fencei_over = 0;
    #1;
    tests_run++;
    if (bus.req_i_ready !== 1'b1 || bus.req_o_valid !== 1'b0) begin
      fails++; $display("FAIL fencei_after: got r=%b v=%b want 1 0", bus.req_i_ready, bus.req_o_valid);
    end
  endtask

  task automatic test_flush();
    bus.req_o_ready = 0;
    for (int i = 0; i < 2; i++) begin
      bus.req_i_valid = 1; bus.req_i_nojump = 1; bus.req_i_pc = 32'h100 + 32'(4 * i);
      tick();
    end
    bus.req_i_pc = 32'h600; bus.req_i_flush = 1; bus.req_i_flush_pc = 32'h400;
    #1;
    tests_run++;
    if (bus.req_i_ready !== 1'b0 || bus.req_o_valid !== 1'b1 || bus.req_o_pc !== 32'h400) begin
      fails++;
      $display("FAIL flush_now: got r=%b %b/%h want r=0 1/400", bus.req_i_ready, bus.req_o_valid,
               bus.req_o_pc);
    end
    tick();
    clear_inputs();
    #1;
    tests_run++;
    if (bus.req_o_valid !== 1'b1 || bus.req_o_pc !== 32'h400 || bus.gen_busy !== 1'b1) begin
      fails++;
      $display("FAIL flush_hold: got %b/%h busy=%b want 1/400 1", bus.req_o_valid, bus.req_o_pc,
               bus.gen_busy);
    end
    bus.req_o_ready = 1;
    tick();
    tests_run++;
    if (bus.req_o_valid !== 1'b0 || bus.gen_busy !== 1'b0) begin
      fails++; $display("FAIL flush_sole: got v=%b busy=%b want 0 0", bus.req_o_valid, bus.gen_busy);
    end
  endtask

  task automatic test_branch_wrap();
    logic [31:0] pcs [2];
    logic [31:0] imms [2];
    logic        tkn [2];
    logic [31:0] exp [2];
    pcs[0] = 32'hFFFFFFFC; imms[0] = 32'h40;       tkn[0] = 0; exp[0] = 32'h0;
    pcs[1] = 32'h1000;     imms[1] = 32'hFFFFFFF0; tkn[1] = 1; exp[1] = 32'hFF0;
    for (int i = 0; i < 2; i++) begin
      bus.req_i_valid = 1; bus.req_i_bxx = 1; bus.req_i_pc = pcs[i]; bus.req_i_imm = imms[i];
      bus.req_i_bxx_taken = tkn[i];
      tick();
      clear_inputs();
      #1;
      tests_run++;
      if (bus.req_o_valid !== 1'b1 || bus.req_o_pc !== exp[i]) begin
        fails++;
        $display("FAIL branch%0d: got %b/%h want 1/%h", i, bus.req_o_valid, bus.req_o_pc, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bus.req_o_ready = 0;
    bus.req_i_valid = 1; bus.req_i_nojump = 1; bus.req_i_pc = 32'h700;
    tick();
    clear_inputs();
    #1;
    tests_run++;
    if (bus.req_o_valid !== 1'b1 || bus.req_o_pc !== 32'h704) begin
      fails++; $display("FAIL rmid_queued: got %b/%h want 1/704", bus.req_o_valid, bus.req_o_pc);
    end
    reset = 1;
    #1;
    tests_run++;
    if (bus.req_o_valid !== 1'b0 || bus.gen_busy !== 1'b0) begin
      fails++; $display("FAIL rmid_reset: got v=%b busy=%b want 0 0", bus.req_o_valid, bus.gen_busy);
    end
    tick();
    reset = 0;
    tick();
    tests_run++;
    if (bus.req_o_valid !== 1'b1 || bus.req_o_pc !== 32'h80000000) begin
      fails++; $display("FAIL rmid_boot: got %b/%h want 1/80000000", bus.req_o_valid, bus.req_o_pc);
    end
    bus.req_o_ready = 1;
    tick();
    tests_run++;
    if (bus.req_o_valid !== 1'b0) begin
      fails++; $display("FAIL rmid_drained: got v=%b want 0", bus.req_o_valid);
    end
  endtask

  initial begin
    bus8.req_i_flush = 0;  bus8.req_i_flush_pc = '0; bus8.req_i_valid = 0; bus8.req_i_pc = '0;
    bus8.req_i_bxx = 0;    bus8.req_i_jal = 0;       bus8.req_i_rs1en = 0; bus8.req_i_rs1dep = 0;
    bus8.req_i_bxx_taken = 0; bus8.req_i_src1 = '0;  bus8.req_i_imm = '0;  bus8.req_i_fencei = 0;
    bus8.req_i_nojump = 0; bus8.req_i_fencei_over = 0; bus8.req_o_ready = 1;
    test_reset();
    test_seq();
    test_jalr_wait();
    test_back_to_back();
    test_fencei();
    test_flush();
    test_branch_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
